// File: rtl/lcd_scanout_pkg.sv
// Shared constants and types for the LCD scan-out path: panel timing, NES window
// geometry, vbuf addressing and the control word carried through the read-latency pipe.
package lcd_scanout_pkg;

  localparam int H_ACTIVE = 480;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 41;
  localparam int H_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 272;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 10;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int NES_W  = 256;
  localparam int NES_H  = 240;
  localparam int X_OFS  = 112;
  localparam int Y_OFS  = 16;
  localparam int RD_LAT = 2;

  localparam int ADDR_W = 17;
  localparam int HCNT_W = 10;
  localparam int VCNT_W = 9;

  localparam logic [7:0] BORDER_IDX = 8'h0F;

  typedef logic [HCNT_W-1:0] hcnt_t;
  typedef logic [VCNT_W-1:0] vcnt_t;
  typedef logic [ADDR_W-1:0] vaddr_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic in_win;
  } scan_ctl_t;

  localparam scan_ctl_t SCAN_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, in_win: 1'b0};

  function automatic logic in_span(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Free-running panel raster counters with raw (undelayed) active, sync and frame-start flags.
module lcd_timing_gen
  import lcd_scanout_pkg::*;
#(
  parameter int HACT = H_ACTIVE,
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VACT = V_ACTIVE,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP
) (
  input  logic  clk,
  input  logic  rst_n,
  output hcnt_t hcnt,
  output vcnt_t vcnt,
  output logic  active,
  output logic  hsync,
  output logic  vsync,
  output logic  frame_start
);

  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (int'(hcnt) == HTOT - 1) begin
      hcnt <= '0;
      vcnt <= (int'(vcnt) == VTOT - 1) ? '0 : vcnt + vcnt_t'(1);
    end else begin
      hcnt <= hcnt + hcnt_t'(1);
    end
  end

  always_comb begin
    active      = (int'(hcnt) < HACT) && (int'(vcnt) < VACT);
    hsync       = !in_span(int'(hcnt), HACT + HFP, HSW);
    vsync       = !in_span(int'(vcnt), VACT + VFP, VSW);
    frame_start = (hcnt == '0) && (vcnt == '0);
  end

endmodule

// File: rtl/lcd_scanout.sv
// LCD-side reader of the double-buffered vbuf: centres the NES frame on the panel,
// issues vbuf reads and re-aligns returned palette indices with the delayed sync/DE.
module lcd_scanout
  import lcd_scanout_pkg::*;
#(
  parameter int HACT = H_ACTIVE,
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VACT = V_ACTIVE,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP,
  parameter int XOFS = X_OFS,
  parameter int YOFS = Y_OFS
) (
  input  logic              i_lcd_clk,
  input  logic              i_rstn,
  input  logic              i_wr_bank,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [7:0]        i_rdata,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [7:0]        o_pix,
  output logic              o_rd_bank,
  output logic              o_frame_start
);

  hcnt_t hcnt;
  vcnt_t vcnt;
  logic  active;
  logic  hsync_raw;
  logic  vsync_raw;
  logic  frame_start;

  lcd_timing_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) u_timing (
    .clk         (i_lcd_clk),
    .rst_n       (i_rstn),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active      (active),
    .hsync       (hsync_raw),
    .vsync       (vsync_raw),
    .frame_start (frame_start)
  );

  // No reset on the synchronizer: it keeps tracking the PPU bank while the scan is held in reset.
  logic [1:0] wr_sync;
  logic       wr_bank_s;

  always_ff @(posedge i_lcd_clk) begin
    wr_sync <= {wr_sync[0], i_wr_bank};
  end

  assign wr_bank_s = wr_sync[1];

  logic rd_bank;

  always_ff @(posedge i_lcd_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_bank       <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= frame_start;
      if (frame_start) rd_bank <= ~wr_bank_s;
    end
  end

  assign o_rd_bank = rd_bank;

  logic       in_win;
  logic [7:0] win_x;
  logic [7:0] win_y;

  always_comb begin
    in_win  = active && in_span(int'(hcnt), XOFS, NES_W) && in_span(int'(vcnt), YOFS, NES_H);
    win_x   = hcnt[7:0] - 8'(XOFS);
    win_y   = vcnt[7:0] - 8'(YOFS);
    o_raddr = in_win ? {rd_bank, win_y, win_x} : {rd_bank, 16'h0000};
  end

  // Control travels alongside the vbuf read so it lines up with i_rdata.
  scan_ctl_t ctl_now;
  scan_ctl_t ctl_pipe [RD_LAT];

  assign ctl_now = '{hsync: hsync_raw, vsync: vsync_raw, de: active, in_win: in_win};

  always_ff @(posedge i_lcd_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < RD_LAT; i++) ctl_pipe[i] <= SCAN_IDLE;
    end else begin
      ctl_pipe[0] <= ctl_now;
      for (int i = 1; i < RD_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign o_hsync = ctl_pipe[RD_LAT-1].hsync;
  assign o_vsync = ctl_pipe[RD_LAT-1].vsync;
  assign o_de    = ctl_pipe[RD_LAT-1].de;
  assign o_pix   = ctl_pipe[RD_LAT-1].in_win ? i_rdata : BORDER_IDX;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout on a vertically shortened panel: full 525-clock lines, 16-line frames,
// checked every cycle against a raster-position model plus hand-computed literal points.
module tb_lcd_scanout;

  localparam int HACT = 480;
  localparam int HFP  = 2;
  localparam int HSW  = 41;
  localparam int HBP  = 2;
  localparam int VACT = 12;
  localparam int VFP  = 1;
  localparam int VSW  = 2;
  localparam int VBP  = 1;
  localparam int XOFS = 112;
  localparam int YOFS = 3;
  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;
  localparam int FT   = HTOT * VTOT;
  localparam int LAT  = 2;

  logic        clk;
  logic        rstn;
  logic        wr_bank;
  logic [16:0] raddr;
  logic [7:0]  rdata;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  pix;
  logic        rd_bank;
  logic        frame_start;

  lcd_scanout #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .XOFS(XOFS), .YOFS(YOFS)
  ) dut (
    .i_lcd_clk     (clk),
    .i_rstn        (rstn),
    .i_wr_bank     (wr_bank),
    .o_raddr       (raddr),
    .i_rdata       (rdata),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_de          (de),
    .o_pix         (pix),
    .o_rd_bank     (rd_bank),
    .o_frame_start (frame_start)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- vbuf stub: data = x ^ y, two-clock read latency ----------------
  logic [7:0] rd_s1;
  always @(posedge clk) begin
    rd_s1 <= raddr[15:8] ^ raddr[7:0];
    rdata <= rd_s1;
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n = 0;
  logic rb_m = 1'b0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at n=%0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic win_at(input int p);
    int h, v;
    h = p % HTOT;
    v = p / HTOT;
    return (h < HACT) && (v < VACT) && (h >= XOFS) && (h < XOFS + 256) && (v >= YOFS) && (v < YOFS + 240);
  endfunction

  function automatic logic [10:0] pipe_word(input int p);
    int h, v;
    logic act, hs, vs;
    logic [7:0] px;
    h   = p % HTOT;
    v   = p / HTOT;
    act = (h < HACT) && (v < VACT);
    hs  = !((h >= HACT + HFP) && (h < HACT + HFP + HSW));
    vs  = !((v >= VACT + VFP) && (v < VACT + VFP + VSW));
    px  = win_at(p) ? 8'((h - XOFS) ^ (v - YOFS)) : 8'h0F;
    return {hs, vs, act, px};
  endfunction

  function automatic logic [16:0] exp_addr(input int p, input logic bank);
    int h, v;
    h = p % HTOT;
    v = p / HTOT;
    return win_at(p) ? {bank, 8'(v - YOFS), 8'(h - XOFS)} : {bank, 16'h0000};
  endfunction

  // n counts clock edges since reset release, i.e. the raster position before each edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n    <= 0;
      rb_m <= 1'b0;
      exp_q.delete();
    end else begin
      exp_q.push_back(pipe_word(n % FT));
      if (n % FT == 0) rb_m <= ~wr_bank;
      n <= n + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [10:0] w;
    if (!rstn) begin
      check("rst_raddr", 32'(raddr), 32'h0);
      check("rst_rd_bank", 32'(rd_bank), 32'h0);
      check("rst_frame_start", 32'(frame_start), 32'h0);
      check("rst_hsync", 32'(hsync), 32'h1);
      check("rst_vsync", 32'(vsync), 32'h1);
      check("rst_de", 32'(de), 32'h0);
      check("rst_pix", 32'(pix), 32'h0F);
    end else begin
      check("raddr", 32'(raddr), 32'(exp_addr(n % FT, rb_m)));
      check("rd_bank", 32'(rd_bank), 32'(rb_m));
      check("frame_start", 32'(frame_start), 32'((n >= 1) && ((n - 1) % FT == 0)));
      if (exp_q.size() >= LAT) w = exp_q.pop_front();
      else w = {1'b1, 1'b1, 1'b0, 8'h0F};
      check("hsync", 32'(hsync), 32'(w[10]));
      check("vsync", 32'(vsync), 32'(w[9]));
      check("de", 32'(de), 32'(w[8]));
      check("pix", 32'(pix), 32'(w[7:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_n: reached n=%0d, required %0d", n, target);
    end
  endtask

  task automatic drive_wr(input int target, input logic val);
    wait_n(target);
    #2 wr_bank = val;
  endtask

  function automatic int rand_h();
    return int'($urandom_range(HTOT - 1, 0));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cnt_hs, cnt_de, cnt_vs, cnt_fs;
    rstn    = 1'b0;
    wr_bank = 1'b1;
    repeat (5) @(negedge clk);
    check("lit_rst_hsync", 32'(hsync), 32'h1);
    check("lit_rst_pix", 32'(pix), 32'h0F);
    #2 rstn = 1'b1;

    // window entry and exit on frame 0 (bank 0 displayed)
    wait_n(YOFS * HTOT + XOFS);
    check("lit_win_first_addr", 32'(raddr), 32'h00000);
    wait_n(YOFS * HTOT + XOFS + 1);
    check("lit_col111_border", 32'(pix), 32'h0F);
    wait_n(YOFS * HTOT + XOFS + 2);
    check("lit_first_pix", 32'(pix), 32'h00);
    check("lit_first_de", 32'(de), 32'h1);
    wait_n((YOFS + 1) * HTOT + XOFS + 255);
    check("lit_last_col_addr", 32'(raddr), 32'h001FF);
    wait_n((YOFS + 1) * HTOT + XOFS + 257);
    check("lit_last_col_pix", 32'(pix), 32'hFE);
    wait_n((YOFS + 1) * HTOT + XOFS + 258);
    check("lit_col368_border", 32'(pix), 32'h0F);

    // sync and DE budgets
    wait_n(5 * HTOT);
    cnt_hs = 0;
    for (int i = 0; i < HTOT; i++) begin
      if (!hsync) cnt_hs++;
      @(negedge clk);
    end
    check("lit_hsync_low_per_line", 32'(cnt_hs), 32'd41);

    wait_n(FT);
    cnt_de = 0; cnt_vs = 0; cnt_fs = 0;
    for (int i = 0; i < FT; i++) begin
      if (de) cnt_de++;
      if (!vsync) cnt_vs++;
      if (frame_start) cnt_fs++;
      @(negedge clk);
    end
    check("lit_de_per_frame", 32'(cnt_de), 32'd5760);
    check("lit_vsync_low_per_frame", 32'(cnt_vs), 32'd1050);
    check("lit_frame_start_per_frame", 32'(cnt_fs), 32'd1);

    // single toggle in frame 2, then 0->1 mid frame 3
    drive_wr(2 * FT + int'($urandom_range(VTOT - 2, 1)) * HTOT + rand_h(), 1'b0);
    wait_n(3 * FT);
    check("lit_bank_hold_f2", 32'(rd_bank), 32'h0);
    wait_n(3 * FT + 1);
    check("lit_bank_new_f3", 32'(rd_bank), 32'h1);
    drive_wr(3 * FT + 8 * HTOT + rand_h(), 1'b1);
    wait_n(4 * FT);
    check("lit_bank_hold_f3", 32'(rd_bank), 32'h1);
    wait_n(4 * FT + 1);
    check("lit_bank_new_f4", 32'(rd_bank), 32'h0);

    // several toggles in frame 4; only the final level counts
    drive_wr(4 * FT + 2 * HTOT + rand_h(), 1'b0);
    drive_wr(4 * FT + 7 * HTOT + rand_h(), 1'b1);
    drive_wr(4 * FT + 12 * HTOT + rand_h(), 1'b0);
    wait_n(5 * FT);
    check("lit_bank_hold_f4", 32'(rd_bank), 32'h0);
    wait_n(5 * FT + 1);
    check("lit_bank_new_f5", 32'(rd_bank), 32'h1);

    // asynchronous reset mid-frame
    wait_n(5 * FT + 10 * HTOT + 300);
    #2 rstn = 1'b0;
    #1;
    check("lit_async_hsync", 32'(hsync), 32'h1);
    check("lit_async_vsync", 32'(vsync), 32'h1);
    check("lit_async_de", 32'(de), 32'h0);
    check("lit_async_pix", 32'(pix), 32'h0F);
    check("lit_async_raddr", 32'(raddr), 32'h0);
    check("lit_async_rd_bank", 32'(rd_bank), 32'h0);
    check("lit_async_frame_start", 32'(frame_start), 32'h0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    wait_n(1);
    check("lit_restart_de_low", 32'(de), 32'h0);
    wait_n(2);
    check("lit_restart_de_high", 32'(de), 32'h1);
    wait_n(YOFS * HTOT + XOFS);
    check("lit_restart_win_addr", 32'(raddr), 32'h10000);
    wait_n(YOFS * HTOT + XOFS + 2);
    check("lit_restart_pix", 32'(pix), 32'h00);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
